cache_mem_arbiter: RTL and testbench

// - Shares the single CPU-wrapper memory port between the instruction cache (I) and data cache (D) miss/uncached paths.
// - Grants one cache at a time and locks the grant until that cache drops its request.
// - A 4-beat line fill (req held high across beats) is never interleaved with the other cache.
// - Forwards the granted cache's req/addr/write/data/type downstream, and the downstream wait/data back to it.

---
 rtl/cache_mem_arbiter_if.sv | 47 ++++
 rtl/cache_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two caches (I and D), the arbiter and the CPU-wrapper
// memory port.
//
// Handshake: a cache raises x_req and keeps it high for its whole transaction,
// which may be several beats. A beat completes on any cycle with mem_req=1 and
// mem_wait=0. x_wait is the cache's stall and x_out is the read data, which is
// only meaningful while x_wait=0. Dropping x_req ends the transaction.
//
// Modports:
//   slave  - the arbiter. It takes the cache requests and mem_out/mem_wait, and
//            drives the memory request and the per-cache wait/data.
//   master - the environment: the caches plus the CPU wrapper.
interface cache_mem_arbiter_if;
  // I-cache side
  logic        I_req;
  logic [31:0] I_addr;
  logic [31:0] I_out;
  logic        I_wait;
  // D-cache side
  logic        D_req;
  logic        D_write;
  logic [31:0] D_addr;
  logic [31:0] D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        D_wait;
  // CPU-wrapper memory port
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [2:0]  mem_type;
  logic [31:0] mem_out;
  logic        mem_wait;

  modport slave (
    input  I_req, I_addr, D_req, D_write, D_addr, D_in, D_type, mem_out, mem_wait,
    output I_out, I_wait, D_out, D_wait,
    output mem_req, mem_write, mem_addr, mem_in, mem_type
  );

  modport master (
    output I_req, I_addr, D_req, D_write, D_addr, D_in, D_type, mem_out, mem_wait,
    input  I_out, I_wait, D_out, D_wait,
    input  mem_req, mem_write, mem_addr, mem_in, mem_type
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbiter that shares the single CPU-wrapper memory port between the I-cache
// and the D-cache.
//
// A grant is locked until the granted cache drops its request, so a multi-beat
// line fill is never interleaved with the other cache. The arbiter forwards the
// granted cache's request downstream and returns mem_wait to that cache. The
// other cache stalls.
//
// Ports:
//   clk, rst     - clock; asynchronous active-high reset
//   bus          - cache/memory bundle (cache_mem_arbiter_if.slave)
//   err_overrun  - sticky: more than MAX_BEATS beats completed in one grant
//   err_timeout  - sticky: wrapper stalled TIMEOUT consecutive cycles while granted
//   o_dbg_state  - current FSM state (0 = IDLE, 1 = GNT_I, 2 = GNT_D)
module cache_mem_arbiter #(
  parameter int RR_MODE   = 1,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_arbiter_if.slave    bus,
  output logic                  err_overrun,
  output logic                  err_timeout,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;      // 1 when the most recently released grant was D
  logic [2:0]  r_beat_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_err_overrun;
  logic        r_err_timeout;
  logic        w_granted;
  logic        w_beat;
  logic        w_stall;

  // State register. last_gnt is updated only when a grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == GNT_I && !bus.I_req) begin
        r_last_d <= 1'b0;
      end else if (r_state == GNT_D && !bus.D_req) begin
        r_last_d <= 1'b1;
      end
    end
  end

  // Next state and datapath steering. The downstream signals depend only on
  // the registered state, so a new request always costs one IDLE cycle.
  always_comb begin
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_in    = 32'd0;
    bus.mem_type  = 3'd0;
    bus.I_wait    = bus.I_req;
    bus.D_wait    = bus.D_req;
    case (r_state)
      IDLE: begin
        if (bus.I_req && bus.D_req) begin
          // Round-robin favours the cache that did not hold the last grant.
          // Fixed priority always favours D.
          w_next = (RR_MODE != 0 && r_last_d) ? GNT_I : GNT_D;
        end else if (bus.I_req) begin
          w_next = GNT_I;
        end else if (bus.D_req) begin
          w_next = GNT_D;
        end
      end
      GNT_I: begin
        bus.mem_req  = bus.I_req;
        bus.mem_addr = bus.I_addr;
        bus.I_wait   = bus.mem_wait;
        if (!bus.I_req) w_next = IDLE;
      end
      GNT_D: begin
        bus.mem_req   = bus.D_req;
        bus.mem_write = bus.D_write;
        bus.mem_addr  = bus.D_addr;
        bus.mem_in    = bus.D_in;
        bus.mem_type  = bus.D_type;
        bus.D_wait    = bus.mem_wait;
        if (!bus.D_req) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.I_out = bus.mem_out;
  assign bus.D_out = bus.mem_out;

  assign w_granted = (r_state != IDLE);
  assign w_beat    = w_granted && bus.mem_req && !bus.mem_wait;
  assign w_stall   = w_granted && bus.mem_req && bus.mem_wait;

  // Beat and stall monitors. Every grant is entered from IDLE, so clearing
  // the beat count while idle is the same as clearing it on grant entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt    <= 3'd0;
      r_to_cnt      <= 8'd0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (!w_granted) begin
        r_beat_cnt <= 3'd0;
      end else if (w_beat) begin
        if (r_beat_cnt == 3'(MAX_BEATS)) r_err_overrun <= 1'b1;
        r_beat_cnt <= r_beat_cnt + 3'd1;
      end
      if (w_stall) begin
        if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
        // The flag rises on the same edge at which the count reaches TIMEOUT.
        if (r_to_cnt >= 8'(TIMEOUT - 1)) r_err_timeout <= 1'b1;
      end else begin
        r_to_cnt <= 8'd0;
      end
    end
  end

  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int MAX_BEATS = 4;
  localparam int TIMEOUT   = 255;

  logic clk;
  logic rst;
  logic err_overrun;
  logic err_timeout;
  logic [1:0] dbg_state;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.RR_MODE(1), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = I-cache, 2 = D-cache. last: the most recent releaser.
  int m_owner, m_last, m_beats, m_stall_run;
  bit m_ovr, m_to;

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_beats = 0; m_stall_run = 0; m_ovr = 0; m_to = 0;
  endtask

  function automatic logic owner_req();
    if (m_owner == 1) return bus.I_req;
    if (m_owner == 2) return bus.D_req;
    return 1'b0;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (owner_req()) begin
      if (!bus.mem_wait) begin
        m_beats++;
        if (m_beats > MAX_BEATS) m_ovr = 1;
        m_stall_run = 0;
      end else begin
        m_stall_run++;
        if (m_stall_run >= TIMEOUT) m_to = 1;
      end
    end else begin
      m_stall_run = 0;
    end
    if (m_owner == 0) begin
      m_beats = 0;
      if (bus.I_req && bus.D_req) m_owner = (m_last == 2) ? 1 : 2;
      else if (bus.I_req)         m_owner = 1;
      else if (bus.D_req)         m_owner = 2;
    end else if (m_owner == 1 && !bus.I_req) begin
      m_last = 1; m_owner = 0;
    end else if (m_owner == 2 && !bus.D_req) begin
      m_last = 2; m_owner = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_addr, e_in;
    logic e_wr;
    logic [2:0] e_type;
    e_addr = (m_owner == 1) ? bus.I_addr : (m_owner == 2) ? bus.D_addr : 32'd0;
    e_wr   = (m_owner == 2) ? bus.D_write : 1'b0;
    e_in   = (m_owner == 2) ? bus.D_in : 32'd0;
    e_type = (m_owner == 2) ? bus.D_type : 3'd0;
    chk("mem_req",   {31'd0, bus.mem_req},   {31'd0, owner_req()});
    chk("mem_addr",  bus.mem_addr,           e_addr);
    chk("mem_write", {31'd0, bus.mem_write}, {31'd0, e_wr});
    chk("mem_in",    bus.mem_in,             e_in);
    chk("mem_type",  {29'd0, bus.mem_type},  {29'd0, e_type});
    chk("I_wait", {31'd0, bus.I_wait}, {31'd0, (m_owner == 1) ? bus.mem_wait : bus.I_req});
    chk("D_wait", {31'd0, bus.D_wait}, {31'd0, (m_owner == 2) ? bus.mem_wait : bus.D_req});
    chk("I_out", bus.I_out, bus.mem_out);
    chk("D_out", bus.D_out, bus.mem_out);
    chk("err_overrun", {31'd0, err_overrun}, {31'd0, m_ovr});
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
    chk("state", {30'd0, dbg_state}, 32'(m_owner));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.I_req = 0; bus.I_addr = 32'h0000_1000;
    bus.D_req = 0; bus.D_write = 0; bus.D_addr = 32'h8000_2000;
    bus.D_in = 0; bus.D_type = 0; bus.mem_out = 32'h5555_AAAA; bus.mem_wait = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already applied; check at the falling edge, then clock the model.
  task automatic run_cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic i_req;
    logic d_req;
    logic mem_wait;
    logic exp_req;
    int   exp_sel;   // 0: no address, 1: I_addr, 2: D_addr
    logic exp_iw;
    logic exp_dw;
  } vec_t;

  function automatic vec_t mk(logic ir, logic dr, logic w, logic er, int sel, logic iw, logic dw);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.mem_wait = w; v.exp_req = er;
    v.exp_sel = sel; v.exp_iw = iw; v.exp_dw = dw;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [31:0] e_addr;
    bit saw_i, iw_low;
    logic pat [8];

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);  // idle
    vecs[1]  = mk(1, 0, 1, 0, 0, 1, 0);  // I seen in IDLE: bubble
    vecs[2]  = mk(1, 0, 1, 1, 1, 1, 0);  // GNT_I, wrapper stalls
    vecs[3]  = mk(1, 1, 0, 1, 1, 0, 1);  // beat; D waits
    vecs[4]  = mk(0, 1, 0, 0, 1, 0, 1);  // I releases
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, 1);  // IDLE bubble before D
    vecs[6]  = mk(1, 1, 1, 1, 2, 1, 1);  // GNT_D locked, I waits
    vecs[7]  = mk(1, 1, 0, 1, 2, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 2, 1, 0);  // D releases, last = D
    vecs[9]  = mk(1, 1, 0, 0, 0, 1, 1);  // both: round-robin picks I
    vecs[10] = mk(1, 1, 0, 1, 1, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0);

    model_reset();
    do_reset();
    // reset state
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      bus.I_req = vecs[i].i_req; bus.D_req = vecs[i].d_req; bus.mem_wait = vecs[i].mem_wait;
      @(negedge clk);
      e_addr = (vecs[i].exp_sel == 1) ? 32'h0000_1000 : (vecs[i].exp_sel == 2) ? 32'h8000_2000 : 32'd0;
      chk($sformatf("vec%0d_mem_req", i), {31'd0, bus.mem_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, e_addr);
      chk($sformatf("vec%0d_I_wait", i), {31'd0, bus.I_wait}, {31'd0, vecs[i].exp_iw});
      chk($sformatf("vec%0d_D_wait", i), {31'd0, bus.D_wait}, {31'd0, vecs[i].exp_dw});
      @(posedge clk);
      model_edge();
      #1;
    end

    // Both rise together straight after reset: D first, then I after one IDLE cycle.
    do_reset();
    bus.I_req = 1; bus.D_req = 1;
    run_cycle();
    chk("tie_first_is_d", {30'd0, dbg_state}, 32'd2);
    chk("tie_d_addr", bus.mem_addr, 32'h8000_2000);
    bus.D_req = 0;
    run_cycle();
    chk("tie_bubble_idle", {30'd0, dbg_state}, 32'd0);
    chk("tie_bubble_no_req", {31'd0, bus.mem_req}, 32'd0);
    run_cycle();
    chk("tie_then_i", bus.mem_addr, 32'h0000_1000);
    chk("tie_then_i_req", {31'd0, bus.mem_req}, 32'd1);
    bus.I_req = 0;
    run_cycle();

    // D write forwarding.
    bus.D_req = 1; bus.D_write = 1; bus.D_in = 32'hDEADBEEF; bus.D_type = 3'b010;
    run_cycle();
    chk("wr_mem_write", {31'd0, bus.mem_write}, 32'd1);
    chk("wr_mem_in", bus.mem_in, 32'hDEADBEEF);
    chk("wr_mem_type", {29'd0, bus.mem_type}, 32'd2);
    run_cycle();
    bus.D_req = 0; bus.D_write = 0; bus.D_in = 0; bus.D_type = 0;
    run_cycle();
    run_cycle();

    // Line fill: four beats with mem_wait 1,0,1,0,...; I asks in the middle.
    do_reset();
    bus.I_addr = 32'h0000_4440; bus.D_addr = 32'h8000_7770;
    pat = '{1, 0, 1, 0, 1, 0, 1, 0};
    saw_i = 0; iw_low = 0;
    bus.D_req = 1;
    run_cycle();
    for (int k = 0; k < 8; k++) begin
      bus.mem_wait = pat[k];
      if (k == 2) bus.I_req = 1;
      #1;
      if (bus.mem_addr == bus.I_addr) saw_i = 1;
      if (k >= 2 && !bus.I_wait) iw_low = 1;
      run_cycle();
    end
    chk("fill_no_i_addr", {31'd0, saw_i}, 32'd0);
    chk("fill_i_held", {31'd0, iw_low}, 32'd0);
    chk("fill_no_overrun", {31'd0, err_overrun}, 32'd0);
    bus.D_req = 0; bus.mem_wait = 0;
    run_cycle();
    run_cycle();
    chk("fill_then_i", bus.mem_addr, 32'h0000_4440);
    bus.I_req = 0;
    run_cycle();

    // Overrun: five beats in one D grant.
    do_reset();
    bus.D_req = 1;
    repeat (5) run_cycle();   // IDLE cycle + four beats
    chk("ovr_after4", {31'd0, err_overrun}, 32'd0);
    run_cycle();              // fifth beat
    chk("ovr_after5", {31'd0, err_overrun}, 32'd1);
    bus.D_req = 0;
    repeat (3) run_cycle();
    chk("ovr_sticky", {31'd0, err_overrun}, 32'd1);

    // Timeout: wrapper stalls while D is granted.
    do_reset();
    bus.D_req = 1; bus.mem_wait = 1;
    run_cycle();              // IDLE bubble
    repeat (TIMEOUT - 1) run_cycle();
    chk("to_before", {31'd0, err_timeout}, 32'd0);
    run_cycle();
    chk("to_at_limit", {31'd0, err_timeout}, 32'd1);
    repeat (3) run_cycle();
    chk("to_sticky", {31'd0, err_timeout}, 32'd1);

    // Asynchronous reset in the middle of the stalled D grant.
    chk("mid_req_before_rst", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("post_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("post_rst_overrun", {31'd0, err_overrun}, 32'd0);
    chk("post_rst_timeout", {31'd0, err_timeout}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) bus.I_req = ~bus.I_req;
      if ($urandom_range(0, 3) == 0) bus.D_req = ~bus.D_req;
      bus.I_addr   = $urandom;
      bus.D_addr   = $urandom;
      bus.D_write  = 1'($urandom_range(0, 1));
      bus.D_in     = $urandom;
      bus.D_type   = 3'($urandom_range(0, 7));
      bus.mem_out  = $urandom;
      bus.mem_wait = ($urandom_range(0, 2) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
